// File: rtl/eth_phy_10g_rx_bitslip_align.sv
// Receive-side 66-bit block aligner: barrel-selects a 66-bit window from two
// consecutive SERDES words at an offset stepped by rate-limited bitslip requests.
module eth_phy_10g_rx_bitslip_align #(
    parameter int DATA_WIDTH   = 64,
    parameter int HDR_WIDTH    = 2,
    parameter int BIT_REVERSE  = 0,
    parameter int SLIP_HOLDOFF = 4
) (
    input  logic                  rx_clk,
    input  logic                  rx_rst_n,
    input  logic [DATA_WIDTH-1:0] serdes_rx_data,
    input  logic [HDR_WIDTH-1:0]  serdes_rx_hdr,
    input  logic                  serdes_rx_bitslip,
    output logic [DATA_WIDTH-1:0] aligned_rx_data,
    output logic [HDR_WIDTH-1:0]  aligned_rx_hdr,
    output logic                  aligned_valid,
    output logic [6:0]            slip_offset,
    output logic                  slip_busy,
    output logic [7:0]            slip_count
);

    localparam int              BLK_W     = DATA_WIDTH + HDR_WIDTH;
    localparam logic [6:0]      OFF_MAX   = 7'(BLK_W - 1);
    localparam logic [3:0]      HOLD_LOAD = 4'(SLIP_HOLDOFF);

    logic [DATA_WIDTH-1:0] data_in;
    logic [HDR_WIDTH-1:0]  hdr_in;
    logic [BLK_W-1:0]      word;
    logic [BLK_W-1:0]      prev_reg;
    logic [2*BLK_W-1:0]    window;
    logic [BLK_W-1:0]      shifted;
    logic                  prev_ok;
    logic                  wrap_hold;
    logic [3:0]            holdoff;
    logic                  accept;

    // Some SERDES deliver each field MSB-first; flip each field independently.
    if (BIT_REVERSE != 0) begin : g_rev
        always_comb begin
            data_in = '0;
            hdr_in  = '0;
            for (int i = 0; i < DATA_WIDTH; i++) data_in[i] = serdes_rx_data[DATA_WIDTH-1-i];
            for (int i = 0; i < HDR_WIDTH; i++)  hdr_in[i]  = serdes_rx_hdr[HDR_WIDTH-1-i];
        end
    end else begin : g_fwd
        assign data_in = serdes_rx_data;
        assign hdr_in  = serdes_rx_hdr;
    end

    assign word      = {data_in, hdr_in};
    assign window    = {word, prev_reg};
    assign shifted   = window[slip_offset +: BLK_W];
    assign slip_busy = (holdoff != 4'd0);
    assign accept    = serdes_rx_bitslip & ~slip_busy;

    // NOTE: every register, including the datapath, is cleared by the synchronous
    // reset and all state updates use non-blocking assignments.
    always_ff @(posedge rx_clk) begin
        if (!rx_rst_n) begin
            prev_reg        <= '0;
            prev_ok         <= 1'b0;
            aligned_rx_data <= '0;
            aligned_rx_hdr  <= '0;
            aligned_valid   <= 1'b0;
        end else begin
            prev_reg        <= word;
            prev_ok         <= 1'b1;
            aligned_rx_hdr  <= shifted[HDR_WIDTH-1:0];
            aligned_rx_data <= shifted[BLK_W-1:HDR_WIDTH];
            // The first load after a 65->0 wrap straddles a dropped block.
            aligned_valid   <= prev_ok & ~wrap_hold;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (!rx_rst_n) begin
            slip_offset <= '0;
            slip_count  <= '0;
            holdoff     <= '0;
            wrap_hold   <= 1'b0;
        end else if (accept) begin
            slip_offset <= (slip_offset == OFF_MAX) ? 7'd0 : slip_offset + 7'd1;
            slip_count  <= slip_count + 8'd1;
            holdoff     <= HOLD_LOAD;
            wrap_hold   <= (slip_offset == OFF_MAX);
        end else begin
            wrap_hold <= 1'b0;
            if (slip_busy) holdoff <= holdoff - 4'd1;
        end
    end

endmodule

// File: tb/tb_eth_phy_10g_rx_bitslip_align.sv
// Self-checking bench: a bit-stream reference model predicts the aligned words,
// offset, slip count and holdoff of a normal and a bit-reversed instance.
module tb_eth_phy_10g_rx_bitslip_align;

    localparam int HOLD = 4;

    logic        rx_clk = 1'b0;
    logic        rx_rst_n;
    logic [63:0] d, dr;
    logic [1:0]  h, hr;
    logic        slip;

    logic [63:0] a_data, b_data;
    logic [1:0]  a_hdr, b_hdr;
    logic        a_valid, b_valid, a_busy, b_busy;
    logic [6:0]  a_off, b_off;
    logic [7:0]  a_cnt, b_cnt;

    eth_phy_10g_rx_bitslip_align dut (
        .rx_clk(rx_clk), .rx_rst_n(rx_rst_n),
        .serdes_rx_data(d), .serdes_rx_hdr(h), .serdes_rx_bitslip(slip),
        .aligned_rx_data(a_data), .aligned_rx_hdr(a_hdr), .aligned_valid(a_valid),
        .slip_offset(a_off), .slip_busy(a_busy), .slip_count(a_cnt)
    );

    eth_phy_10g_rx_bitslip_align #(.BIT_REVERSE(1)) dut_rev (
        .rx_clk(rx_clk), .rx_rst_n(rx_rst_n),
        .serdes_rx_data(dr), .serdes_rx_hdr(hr), .serdes_rx_bitslip(slip),
        .aligned_rx_data(b_data), .aligned_rx_hdr(b_hdr), .aligned_valid(b_valid),
        .slip_offset(b_off), .slip_busy(b_busy), .slip_count(b_cnt)
    );

    always #5 rx_clk = ~rx_clk;

    // Reference model: every word since reset release, viewed as one serial stream.
    logic [65:0] words[$];
    int          m_off, m_cnt, m_hold;
    bit          m_wrap;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [65:0] stream_word(input int start);
        logic [65:0] r;
        for (int b = 0; b < 66; b++) r[b] = words[(start + b) / 66][(start + b) % 66];
        return r;
    endfunction

    function automatic logic [63:0] rev64(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = x[63-i];
        return r;
    endfunction

    function automatic logic [65:0] rand_word();
        return {32'($urandom), 32'($urandom), 2'($urandom)};
    endfunction

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [65:0] w, input logic s, input logic rst_v);
        int          n;
        bit          ev;
        logic [65:0] ew;
        d = w[65:2]; h = w[1:0];
        dr = rev64(w[65:2]); hr = {w[0], w[1]};
        slip = s; rx_rst_n = rst_v;
        @(posedge rx_clk);
        #1;
        if (!rst_v) begin
            words.delete();
            m_off = 0; m_cnt = 0; m_hold = 0; m_wrap = 0;
            check("rst_word", {a_data, a_hdr}, '0);
            check("rst_word_rev", {b_data, b_hdr}, '0);
            check("rst_valid", 66'(a_valid | b_valid), 0);
            check("rst_offset", 66'(a_off | b_off), 0);
            check("rst_count", 66'(a_cnt | b_cnt), 0);
            check("rst_busy", 66'(a_busy | b_busy), 0);
        end else begin
            words.push_back(w);
            n  = words.size() - 1;
            ev = (n >= 1) && !m_wrap;
            check("valid", 66'(a_valid), 66'(ev));
            check("valid_rev", 66'(b_valid), 66'(ev));
            if (ev) begin
                ew = stream_word(66 * (n - 1) + m_off);
                check("word", {a_data, a_hdr}, ew);
                check("word_rev", {b_data, b_hdr}, ew);
            end
            if (s && m_hold == 0) begin
                m_wrap = (m_off == 65);
                m_off  = (m_off + 1) % 66;
                m_cnt  = (m_cnt + 1) % 256;
                m_hold = HOLD;
            end else begin
                m_wrap = 0;
                if (m_hold > 0) m_hold--;
            end
            check("offset", 66'(a_off), 66'(m_off));
            check("count", 66'(a_cnt), 66'(m_cnt));
            check("busy", 66'(a_busy), 66'(m_hold != 0));
            check("offset_rev", 66'(b_off), 66'(m_off));
        end
    endtask

    logic [65:0] tblk[$];
    logic [65:0] raw;
    logic [19:0] acc_mask;
    logic [7:0]  last_cnt;
    int          low_cycles;
    int          t;

    initial begin
        // Reset for a few edges with a slip request present.
        for (int i = 0; i < 3; i++) step(rand_word(), 1'b1, 1'b0);

        // Constant known word, no slips.
        for (int i = 0; i < 8; i++) step({64'h0123456789ABCDEF, 2'b01}, 1'b0, 1'b1);
        check("const_hdr", 66'(a_hdr), 66'(2'b01));
        check("const_data", 66'(a_data), 66'(64'h0123456789ABCDEF));

        // Stream pre-shifted by 5 bits, aligned by five spaced slip pulses.
        step(rand_word(), 1'b0, 1'b0);
        tblk.delete();
        for (int i = 0; i < 60; i++) tblk.push_back({32'($urandom), 32'($urandom), 2'b01});
        for (int n = 0; n < 50; n++) begin
            for (int b = 0; b < 66; b++) begin
                t = 66 * n + b - 5;
                raw[b] = (t < 0) ? 1'b0 : tblk[t / 66][t % 66];
            end
            step(raw, (n >= 2 && n <= 26 && (n - 2) % 6 == 0), 1'b1);
            if (n >= 28) check("preshift_hdr", 66'(a_hdr), 66'(2'b01));
        end
        check("preshift_offset", 66'(a_off), 66'd5);
        check("preshift_count", 66'(a_cnt), 66'd5);

        // Request held high for 20 cycles: one acceptance every HOLD+1 cycles.
        step(rand_word(), 1'b0, 1'b0);
        acc_mask = '0;
        last_cnt = a_cnt;
        for (int i = 0; i < 20; i++) begin
            step(rand_word(), 1'b1, 1'b1);
            if (a_cnt != last_cnt) acc_mask[i] = 1'b1;
            last_cnt = a_cnt;
        end
        check("held_accept_cycles", 66'(acc_mask), 66'(20'b0000_1000_0100_0010_0001));
        check("held_count", 66'(a_cnt), 66'd4);

        // Walk the offset to 65, then wrap to 0 and look for the single invalid word.
        step(rand_word(), 1'b0, 1'b0);
        for (int i = 0; i < 65 * (HOLD + 1); i++) step(rand_word(), 1'b1, 1'b1);
        check("preset_offset", 66'(a_off), 66'd65);
        check("preset_count", 66'(a_cnt), 66'd65);
        step(rand_word(), 1'b1, 1'b1);
        check("wrap_offset", 66'(a_off), 66'd0);
        check("wrap_count", 66'(a_cnt), 66'd66);
        low_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            step(rand_word(), 1'b0, 1'b1);
            if (!a_valid) low_cycles++;
        end
        check("wrap_invalid_cycles", 66'(low_cycles), 66'd1);

        // Reset during holdoff with a pending request.
        step(rand_word(), 1'b1, 1'b1);
        step(rand_word(), 1'b1, 1'b1);
        step(rand_word(), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(rand_word(), 1'b0, 1'b1);
        check("post_reset_offset", 66'(a_off), 66'd0);

        // Random data, random slips, occasional reset.
        for (int i = 0; i < 400; i++)
            step(rand_word(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) != 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_phy_10g_rx_bitslip_align.md
ETH_PHY_10G_RX_BITSLIP_ALIGN -- requirements
Module: eth_phy_10g_rx_bitslip_align

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the payload width of each 66-bit block.
REQ-002 Parameter HDR_WIDTH, default 2, SHALL set the sync-header width; only 2 is supported.
REQ-003 Parameter BIT_REVERSE, default 0, SHALL reverse the bit order of serdes_rx_data and of serdes_rx_hdr before alignment when set to 1.
REQ-004 Parameter SLIP_HOLDOFF, default 4, range 1..15, SHALL set the cycles after an accepted slip during which further slip requests are ignored.
REQ-005 rx_clk  input  1  rising-edge clock for all logic.
REQ-006 rx_rst_n  input  1  reset, synchronous and active-low.
REQ-007 serdes_rx_data  input  DATA_WIDTH  raw unaligned payload bits from the SERDES.
REQ-008 serdes_rx_hdr  input  HDR_WIDTH  raw unaligned header bits from the SERDES.
REQ-009 serdes_rx_bitslip  input  1  slip request from frame sync; one bit slip per accepted high cycle.
REQ-010 aligned_rx_data  output  DATA_WIDTH  aligned payload to frame sync.
REQ-011 aligned_rx_hdr  output  HDR_WIDTH  aligned header to frame sync.
REQ-012 aligned_valid  output  1  aligned word is valid this cycle.
REQ-013 slip_offset  output  7  current bit offset, 0..65.
REQ-014 slip_busy  output  1  holdoff active; slip requests are ignored.
REQ-015 slip_count  output  8  number of accepted slips, wrapping modulo 256.

Function
REQ-016 The raw word SHALL be W = {serdes_rx_data, serdes_rx_hdr}, 66 bits, hdr in W[1:0], after optional BIT_REVERSE.
REQ-017 The block SHALL register W each cycle into prev_reg and form B = {W_current, prev_reg}, 132 bits.
REQ-018 The output register SHALL load B[slip_offset +: 66]; aligned_rx_hdr = bits[1:0] and aligned_rx_data = bits[65:2].
REQ-019 At slip_offset 0, the word present at edge N SHALL appear on the outputs after edge N+1 (2-edge latency, fixed for all offsets).
REQ-020 A slip request SHALL be accepted when serdes_rx_bitslip = 1, slip_busy = 0 and reset is deasserted.
REQ-021 An accepted slip SHALL increment slip_offset by 1, except that 65 wraps to 0, and SHALL increment slip_count.
REQ-022 The new offset SHALL apply to the output register load on the edge after acceptance.
REQ-023 Acceptance SHALL load a holdoff counter with SLIP_HOLDOFF; slip_busy = (counter != 0); the counter SHALL decrement to 0 once per cycle.
REQ-024 A request held high continuously SHALL yield one accepted slip every SLIP_HOLDOFF+1 cycles.
REQ-025 On wrap 65 -> 0, one block is consumed; aligned_valid SHALL be 0 for exactly the one output cycle that uses the new offset.
REQ-026 A slip request arriving in the same cycle that reset is asserted SHALL be ignored.
REQ-027 Changes to serdes_rx_data or serdes_rx_hdr SHALL NOT affect slip_offset, slip_count or the holdoff counter.

Reset
REQ-028 While rx_rst_n = 0 at a rising edge: slip_offset = 0, slip_count = 0, holdoff counter = 0, slip_busy = 0, prev_reg = 0, aligned_rx_data = 0, aligned_rx_hdr = 0, aligned_valid = 0.
REQ-029 After reset release, aligned_valid SHALL assert on the second rising edge, once prev_reg holds a captured word.
REQ-030 Reset asserted mid-holdoff or mid-operation SHALL discard all state on that edge, with no residual slip applied afterward.

Verification
REQ-031 Stream of constant words with hdr=01 and data=0x0123456789ABCDEF, no slips -> identical words on the outputs 2 edges later; aligned_valid rises on the 2nd edge after release.
REQ-032 Raw stream pre-shifted by 5 bits; pulse bitslip 5 times, spaced by more than SLIP_HOLDOFF -> slip_offset = 5, slip_count = 5, aligned_rx_hdr = 01 on every word thereafter.
REQ-033 bitslip held high for 20 cycles with SLIP_HOLDOFF = 4 -> accepted on cycles 0, 5, 10, 15; slip_count = 4; slip_busy high for 4 cycles after each acceptance.
REQ-034 Offset preset to 65 by 65 accepted slips, then one more slip -> slip_offset = 0, slip_count = 66, and aligned_valid low for exactly one cycle.
REQ-035 rx_rst_n driven low during holdoff with a pending bitslip -> all outputs take the reset values of REQ-028; no slip is accepted on that edge.
REQ-036 BIT_REVERSE = 1 with a bit-reversed input stream -> output identical to the REQ-031 expected words.
